// File: rtl/lmem_pkg.sv
// Shared types and derived widths for the load-memory responder.
// The optional misaligned-request checker is enabled with the macro
// LMEM_MISALIGN_CHK_EN (see lmem_responder.sv).
package lmem_pkg;

   // Responder control states: waiting for a request, counting down the
   // array access latency, and presenting the single-cycle response.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } lmem_state_e;

   // Default geometry, kept here so widths derived from it stay in one place.
   localparam int LMEM_DEPTH_DEF  = 256;
   localparam int LMEM_DATA_W_DEF = 32;
   localparam int LMEM_IDX_W_DEF  = $clog2(LMEM_DEPTH_DEF);
   localparam int LMEM_STRB_W_DEF = LMEM_DATA_W_DEF / 8;

   // Word-index width for a word-addressed array of the given depth.
   function automatic int lmem_idx_w(input int depth);
      return $clog2(depth);
   endfunction

   // Number of byte lanes in a data word.
   function automatic int lmem_strb_w(input int data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/lmem_req_fifo.sv
// In-order request FIFO holding load byte addresses. Pointers carry one extra
// wrap bit so full and empty are distinguished without a separate counter.
module lmem_req_fifo
   import lmem_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int REQ_Q  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [ADDR_W-1:0]          push_addr,
   input  logic                       pop,
   output logic [ADDR_W-1:0]          head_addr,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(REQ_Q):0]     count
);

   localparam int PTR_W = $clog2(REQ_Q);

   logic [ADDR_W-1:0] slot_q [REQ_Q];
   logic [PTR_W:0]    wr_ptr_q;
   logic [PTR_W:0]    rd_ptr_q;
   logic              push_ok;
   logic              pop_ok;

   assign count     = wr_ptr_q - rd_ptr_q;
   assign full      = (count == (PTR_W+1)'(REQ_Q));
   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign push_ok   = push && !full;
   assign pop_ok    = pop && !empty;
   assign head_addr = slot_q[rd_ptr_q[PTR_W-1:0]];

   // Pointer update; a reset drops every queued entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
      end
   end

   // Entry storage is data only and needs no reset.
   always_ff @(posedge clk) begin
      if (push_ok) slot_q[wr_ptr_q[PTR_W-1:0]] <= push_addr;
   end

endmodule

// File: rtl/lmem_responder.sv
// Load-memory responder: queues word-aligned load requests, reads a local
// word-addressed array after LAT cycles and returns one mem_resp pulse per
// request, in order. A side write port preloads data and commits stores.
// Optional: define LMEM_MISALIGN_CHK_EN to flag requests with addr[1:0] != 0
// via mem_err (data forced to zero, array not read).
module lmem_responder
   import lmem_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256,
   parameter int REQ_Q  = 4,
   parameter int LAT    = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [ADDR_W-1:0]      req_addr,
   input  logic                   wr_en,
   input  logic [ADDR_W-1:0]      wr_addr,
   input  logic [DATA_W-1:0]      wr_data,
   input  logic [DATA_W/8-1:0]    wr_strb,
   output logic                   mem_resp,
   output logic [DATA_W-1:0]      mem_data,
   output logic                   mem_err
);

   localparam int IDX_W  = lmem_idx_w(DEPTH);
   localparam int STRB_W = lmem_strb_w(DATA_W);
   localparam int CNT_W  = (LAT > 1) ? $clog2(LAT) : 1;
   localparam int CNT_W_CHK = CNT_W;

   lmem_state_e               state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic                      pop;
   logic                      cap;

   logic [ADDR_W-1:0]         head_addr;
   logic                      fifo_full;
   logic                      fifo_empty;
   logic [$clog2(REQ_Q):0]    fifo_count;

   logic [IDX_W-1:0]          idx_p0;
   logic [IDX_W-1:0]          wr_idx;
   logic [DATA_W-1:0]         mem_q [DEPTH];

   assign req_ready = (fifo_count != ($clog2(REQ_Q)+1)'(REQ_Q));
   assign mem_resp  = (state_q == RESP);
   assign wr_idx    = wr_addr[IDX_W+1:2];

   lmem_req_fifo #(
      .ADDR_W (ADDR_W),
      .REQ_Q  (REQ_Q)
   ) u_req_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (req_valid && req_ready),
      .push_addr (req_addr),
      .pop       (pop),
      .head_addr (head_addr),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // FSM state and latency counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic: pop on IDLE/RESP when work is queued, count down the
   // access latency in BUSY and capture array data on the last BUSY cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pop     = 1'b0;
      cap     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = BUSY;
               cnt_d   = CNT_W'(LAT-1);
            end
         end
         BUSY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               cap     = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = BUSY;
               cnt_d   = CNT_W'(LAT-1);
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // --- stage p0: request popped, word index latched for the array access ---
`ifdef LMEM_MISALIGN_CHK_EN
   logic mis_p0;

   // Latch the head request's word index and misalignment at pop time.
   always_ff @(posedge clk) begin
      if (pop) begin
         idx_p0 <= head_addr[IDX_W+1:2];
         mis_p0 <= |head_addr[1:0];
      end
   end

   // --- stage p1: array sampled into the response registers ---
   // Misaligned requests skip the array and report an error with zero data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_data <= '0;
         mem_err  <= 1'b0;
      end else if (cap) begin
         mem_data <= mis_p0 ? '0 : mem_q[idx_p0];
         mem_err  <= mis_p0;
      end
   end
`else
   // Latch the head request's word index at pop time; low address bits ignored.
   always_ff @(posedge clk) begin
      if (pop) idx_p0 <= head_addr[IDX_W+1:2];
   end

   // --- stage p1: array sampled into the response register ---
   // Capture on the last BUSY edge; the read sees pre-write data on a collision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_data <= '0;
      end else if (cap) begin
         mem_data <= mem_q[idx_p0];
      end
   end

   assign mem_err = 1'b0;
`endif

   // Byte-lane writes into the data array; contents are never reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (wr_strb[b]) mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

   // Address bits above the array and the byte offset do not select storage.
   logic unused_bits;
   assign unused_bits = &{1'b0, wr_addr[ADDR_W-1:IDX_W+2], wr_addr[1:0],
                          head_addr[ADDR_W-1:IDX_W+2], head_addr[1:0],
                          fifo_full, CNT_W_CHK[0]};

endmodule

// File: doc/lmem_responder.md
# lmem_responder

Load-memory responder: the memory side of the load-queue interface. Accepts word-aligned load requests into a small in-order request FIFO, reads a local word-addressed data array after a fixed access latency, and returns one single-cycle `mem_resp` pulse with `mem_data` per request, in request order. A side write port preloads the array and commits stores. Sits between the load queue's memory request output and its `mem_resp`/`mem_data` inputs.

## Interface
- `ADDR_W`, 32, byte-address width
- `DATA_W`, 32, data word width, multiple of 8
- `DEPTH`, 256, data-array depth in words, power of two
- `REQ_Q`, 4, request FIFO depth, power of two, ≥2
- `LAT`, 2, array access latency in cycles, ≥1
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `req_valid`  in  1  load request present
- `req_ready`  out  1  FIFO can accept; equals (fifo count != REQ_Q)
- `req_addr`  in  ADDR_W  byte address of load
- `wr_en`  in  1  array write
- `wr_addr`  in  ADDR_W  byte address of write
- `wr_data`  in  DATA_W  write data
- `wr_strb`  in  DATA_W/8  byte enables
- `mem_resp`  out  1  response valid, one-cycle pulse per request
- `mem_data`  out  DATA_W  response data, valid when `mem_resp`
- `mem_err`  out  1  misaligned-request flag, valid when `mem_resp`

## Operation
- Word index = addr bits [log2(DEPTH)+1 : 2]; upper bits ignored (addresses wrap modulo DEPTH words).
- Request accepted when `req_valid && req_ready`; pushed at that edge. No reordering, no drop.
- FIFO push and pop in the same cycle allowed; when full `req_ready` is 0 even if a pop occurs that cycle.
- FSM states IDLE, BUSY, RESP:
  - IDLE: FIFO non-empty → pop head, latch index, go BUSY with cnt = LAT-1; else stay.
  - BUSY: cnt != 0 → decrement; cnt == 0 → sample array at latched index into `mem_data`, go RESP.
  - RESP: `mem_resp` = 1 for this cycle; FIFO non-empty → pop, go BUSY (cnt = LAT-1); else IDLE.
- Writes: at edge when `wr_en`, bytes with `wr_strb` set are written; others unchanged.
- Read/write collision: array read samples before the write on the same edge (old data); writes on earlier edges are visible.
- Array contents are not reset; bench preloads via write port.

## Timing
- Reset (async assert, sync-safe release): FIFO empty, FSM IDLE, cnt 0, `mem_resp` 0, `mem_data` 0, `mem_err` 0; `req_ready` 1 (count 0).
- Reset mid-operation discards all queued and in-flight requests; no response is emitted for them.
- Latency: request accepted in cycle 0 with FSM idle → `mem_resp` in cycle LAT+2 (LAT=2: cycle 4).
- Steady-state throughput: one response per LAT+1 cycles.
- `mem_resp` never asserted two consecutive cycles; `mem_data`/`mem_err` hold their value until the next capture.

## Configuration
- `LMEM_MISALIGN_CHK_EN` defined: request with addr[1:0] != 0 still occupies a FIFO slot and full latency, does not read the array, responds with `mem_err` = 1 and `mem_data` = 0.
- Not defined: addr[1:0] ignored, misaligned requests read the containing word, `mem_err` tied 0.

## Structure
- Package `lmem_pkg`: state enum `lmem_state_e` (IDLE, BUSY, RESP), index-width and strobe-width localparams derived from DEPTH/DATA_W.
- Sub-module `lmem_req_fifo`: REQ_Q-deep ADDR_W FIFO with push/pop, full/empty, count; wrap-around pointers with extra bit.

## Test plan
- Preload word 5 = 0xDEADBEEF; single request addr 0x14 in cycle 0 → `mem_resp` exactly in cycle 4, `mem_data` 0xDEADBEEF, `mem_err` 0.
- Preload words 0..5 = 0x100+i; hold `req_valid` with addrs 0x0,0x4,…,0x14 → `req_ready` drops after 4 queued, responses 0x100..0x105 in order, spaced 3 cycles apart, no loss.
- Write 0xAABBCCDD to word 3, then `wr_strb` 0b0010 with data 0x00001100 → load addr 0xC returns 0xAABB11DD; write on the capture edge returns old value.
- Address 0x404 with DEPTH=256 → returns contents of word 1 (wrap).
- With `LMEM_MISALIGN_CHK_EN`: load addr 0x6 → `mem_err` 1, `mem_data` 0, same cycle-4 latency; without macro → word 1 data, `mem_err` 0.
- Queue 3 requests, assert `rst` while BUSY → `mem_resp` 0 immediately, no further responses, `req_ready` 1; new request after release responds with normal latency.
